// File: rtl/hazard_stall_controller.sv
// ============================================================================
//  Module   : hazard_stall_controller
//  Purpose  : IF/ID/EX advance/hold/bubble control for load-use hazards,
//             taken-branch flushes and multi-cycle mul/div occupancy of EX.
//             Optional counters enabled by macro HAZARD_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6,
    parameter int PERF_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        decode_RS,
    input  logic [4:0]        decode_RT,
    input  logic              decode_usesRT,
    input  logic [4:0]        exe_RDout,
    input  logic              exe_MemRead,
    input  logic              exe_muldiv,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic              muldiv_busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PERF_W-1:0] perf_load_stalls,
    output logic [PERF_W-1:0] perf_flushes,
    output logic [PERF_W-1:0] perf_muldiv_cycles,
`endif
    output logic              hilo_write
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MULDIV_CYCLES - 2);

    // Reject configurations the busy counter or perf counters cannot represent.
    generate
        if ((MULDIV_CYCLES < 2) || (MULDIV_CYCLES > 63) ||
            (MULDIV_CYCLES - 1 >= (1 << CNT_W)) || (PERF_W < 1)) begin : g_param_check
            $error("hazard_stall_controller: illegal parameter combination");
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_run;
    logic w_load_use;
    logic w_branch_flush;
    logic w_enter_muldiv;
    logic w_load_stall;

    assign w_run = (r_state == ST_RUN);

    assign w_load_use = exe_MemRead && (exe_RDout != 5'd0) &&
                        ((exe_RDout == decode_RS) ||
                         (decode_usesRT && (exe_RDout == decode_RT)));

    // Branch outranks mul/div, which outranks load-use.
    assign w_branch_flush = w_run && branch_taken;
    assign w_enter_muldiv = w_run && !branch_taken && exe_muldiv;
    assign w_load_stall   = w_run && !branch_taken && !exe_muldiv && w_load_use;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_enter_muldiv) begin
                        r_cnt   <= c_cnt_load;
                        // With a 2-cycle op there are no BUSY cycles at all.
                        r_state <= (MULDIV_CYCLES == 2) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_cnt   <= '0;
                    r_state <= ST_RUN;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        muldiv_busy  = 1'b0;
        hilo_write   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_branch_flush) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (w_enter_muldiv) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                end else if (w_load_stall) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            ST_BUSY: begin
                muldiv_busy  = 1'b1;
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
            end
            ST_DONE: begin
                hilo_write   = 1'b1;
                exmem_bubble = 1'b1;
            end
            default: begin
                pc_write = 1'b1;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_load_stalls;
    logic [PERF_W-1:0] r_perf_flushes;
    logic [PERF_W-1:0] r_perf_muldiv_cycles;

    // Saturating counters: hold at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_load_stalls   <= '0;
            r_perf_flushes       <= '0;
            r_perf_muldiv_cycles <= '0;
        end else begin
            if (w_load_stall && !(&r_perf_load_stalls)) begin
                r_perf_load_stalls <= r_perf_load_stalls + 1'b1;
            end
            if (w_branch_flush && !(&r_perf_flushes)) begin
                r_perf_flushes <= r_perf_flushes + 1'b1;
            end
            if ((r_state == ST_BUSY) && !(&r_perf_muldiv_cycles)) begin
                r_perf_muldiv_cycles <= r_perf_muldiv_cycles + 1'b1;
            end
        end
    end

    assign perf_load_stalls   = r_perf_load_stalls;
    assign perf_flushes       = r_perf_flushes;
    assign perf_muldiv_cycles = r_perf_muldiv_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
//  Module   : tb_hazard_stall_controller
//  Purpose  : Directed self-checking bench for hazard_stall_controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;

    localparam int c_mdc = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] decode_RS, decode_RT, exe_RDout;
    logic       decode_usesRT, exe_MemRead, exe_muldiv, branch_taken;
    logic       pc_write, ifid_write, ifid_flush, idex_write;
    logic       idex_bubble, exmem_bubble, muldiv_busy, hilo_write;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_load_stalls, perf_flushes, perf_muldiv_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .MULDIV_CYCLES(c_mdc),
        .CNT_W        (6),
        .PERF_W       (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .decode_RS         (decode_RS),
        .decode_RT         (decode_RT),
        .decode_usesRT     (decode_usesRT),
        .exe_RDout         (exe_RDout),
        .exe_MemRead       (exe_MemRead),
        .exe_muldiv        (exe_muldiv),
        .branch_taken      (branch_taken),
        .pc_write          (pc_write),
        .ifid_write        (ifid_write),
        .ifid_flush        (ifid_flush),
        .idex_write        (idex_write),
        .idex_bubble       (idex_bubble),
        .exmem_bubble      (exmem_bubble),
        .muldiv_busy       (muldiv_busy),
`ifdef HAZARD_PERF_CNT_EN
        .perf_load_stalls  (perf_load_stalls),
        .perf_flushes      (perf_flushes),
        .perf_muldiv_cycles(perf_muldiv_cycles),
`endif
        .hilo_write        (hilo_write)
    );

    // Output bundle {pc,ifid_w,ifid_f,idex_w,idex_b,exmem_b,busy,hilo}.
    logic [7:0] obs;
    assign obs = {pc_write, ifid_write, ifid_flush, idex_write,
                  idex_bubble, exmem_bubble, muldiv_busy, hilo_write};

    localparam logic [7:0] c_dflt   = 8'b1101_0000;
    localparam logic [7:0] c_load   = 8'b0001_1000;
    localparam logic [7:0] c_flush  = 8'b1111_1000;
    localparam logic [7:0] c_entry  = 8'b0000_0100;
    localparam logic [7:0] c_busy   = 8'b0000_0110;
    localparam logic [7:0] c_done   = 8'b1101_0101;

    // Inputs change 1 ns after the rising edge; outputs are checked at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        decode_RS = 5'd0; decode_RT = 5'd0; decode_usesRT = 1'b0;
        exe_RDout = 5'd0; exe_MemRead = 1'b0; exe_muldiv = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle(); next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== c_dflt) begin
            bad++; $display("FAIL reset_defaults: got %b want %b", obs, c_dflt);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        exe_MemRead = 1'b1; exe_RDout = 5'd8; decode_RS = 5'd8;
        @(negedge clk);
        total++;
        if (obs !== c_load) begin
            bad++; $display("FAIL load_use_rs: got %b want %b", obs, c_load);
        end
        next_cycle();
        idle_inputs(); decode_RS = 5'd8;
        @(negedge clk);
        total++;
        if (obs !== c_dflt) begin
            bad++; $display("FAIL load_use_release: got %b want %b", obs, c_dflt);
        end
        next_cycle();
        exe_MemRead = 1'b1; exe_RDout = 5'd0; decode_RS = 5'd0; decode_RT = 5'd0; decode_usesRT = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== c_dflt) begin
            bad++; $display("FAIL load_use_r0: got %b want %b", obs, c_dflt);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_rt_source();
        exe_MemRead = 1'b1; exe_RDout = 5'd9; decode_RT = 5'd9; decode_RS = 5'd3; decode_usesRT = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== c_dflt) begin
            bad++; $display("FAIL rt_unused: got %b want %b", obs, c_dflt);
        end
        next_cycle();
        decode_usesRT = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== c_load) begin
            bad++; $display("FAIL rt_used: got %b want %b", obs, c_load);
        end
        next_cycle();
        exe_MemRead = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== c_dflt) begin
            bad++; $display("FAIL rt_not_load: got %b want %b", obs, c_dflt);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_branch_priority();
        exe_MemRead = 1'b1; exe_RDout = 5'd8; decode_RS = 5'd8; branch_taken = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== c_flush) begin
            bad++; $display("FAIL branch_over_load: got %b want %b", obs, c_flush);
        end
        next_cycle();
        idle_inputs();
        branch_taken = 1'b1; exe_muldiv = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== c_flush) begin
            bad++; $display("FAIL branch_over_muldiv: got %b want %b", obs, c_flush);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total++;
        if (obs !== c_dflt) begin
            bad++; $display("FAIL branch_no_busy: got %b want %b", obs, c_dflt);
        end
        next_cycle();
    endtask

    task automatic test_muldiv();
        logic [7:0] exp_seq [0:4];
        exp_seq[0] = c_entry; exp_seq[1] = c_busy; exp_seq[2] = c_busy;
        exp_seq[3] = c_done;  exp_seq[4] = c_dflt;
        exe_muldiv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            // Hazard-looking inputs during BUSY/DONE must be ignored.
            if (i == 1 || i == 3) begin
                branch_taken = 1'b1; exe_MemRead = 1'b1; exe_RDout = 5'd4; decode_RS = 5'd4;
            end else begin
                branch_taken = 1'b0; exe_MemRead = 1'b0; exe_RDout = 5'd0; decode_RS = 5'd0;
            end
            if (i == 4) exe_muldiv = 1'b0;
            @(negedge clk);
            total++;
            if (obs !== exp_seq[i]) begin
                bad++; $display("FAIL muldiv_cycle%0d: got %b want %b", i, obs, exp_seq[i]);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_busy();
        exe_muldiv = 1'b1;
        next_cycle();
        @(negedge clk);
        total++;
        if (obs !== c_busy) begin
            bad++; $display("FAIL rst_busy_entered: got %b want %b", obs, c_busy);
        end
        next_cycle();
        reset = 1'b1;
        next_cycle(); next_cycle();
        reset = 1'b0; exe_muldiv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs !== c_dflt) begin
                bad++; $display("FAIL rst_busy_after%0d: got %b want %b", i, obs, c_dflt);
            end
            next_cycle();
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (perf_load_stalls !== 32'd0 || perf_flushes !== 32'd0 || perf_muldiv_cycles !== 32'd0) begin
            bad++; $display("FAIL perf_clear: got %0d/%0d/%0d want 0/0/0",
                            perf_load_stalls, perf_flushes, perf_muldiv_cycles);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            exe_MemRead = 1'b1; exe_RDout = 5'd7; decode_RS = 5'd7;
            next_cycle();
            idle_inputs();
            next_cycle();
        end
        branch_taken = 1'b1;
        next_cycle();
        idle_inputs();
        exe_muldiv = 1'b1;
        for (int i = 0; i < c_mdc; i++) next_cycle();
        idle_inputs();
        next_cycle();
        @(negedge clk);
        total++;
        if (perf_load_stalls !== 32'd3 || perf_flushes !== 32'd1 || perf_muldiv_cycles !== 32'd2) begin
            bad++; $display("FAIL perf_counts: got %0d/%0d/%0d want 3/1/2",
                            perf_load_stalls, perf_flushes, perf_muldiv_cycles);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_rt_source();
        test_branch_priority();
        test_muldiv();
        test_reset_in_busy();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
